// File: rtl/out_port_arbiter.sv
// Output-channel arbiter for one mesh-router direction: per-VC round-robin
// grant into a two-entry (VC0/VC1) output buffer drained by the so/ro link.
module out_port_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REQ    = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          polarity_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          so_o,
   input  logic                          ro_i,
   output logic [DATA_WIDTH-1:0]         do_o,
   output logic [1:0]                    obuf_full_o,
   output logic                          vc_err_o,
   output logic [15:0]                   tx_count_o
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [1:0][DATA_WIDTH-1:0] obuf_q, obuf_d;
   logic [1:0]                 full_q, full_d;
   logic [PW-1:0]              ptr0_q, ptr0_d;
   logic [PW-1:0]              ptr1_q, ptr1_d;
   logic                       vc_err_q, vc_err_d;
   logic [15:0]                tx_q, tx_d;

   logic                  v, t, found;
   logic [PW-1:0]         ptr_v, idx, win, nxt;
   logic [DATA_WIDTH-1:0] win_data;

   // Arbitration fills VC==polarity while the link drains the other VC
   assign v     = polarity_i;
   assign t     = ~polarity_i;
   assign ptr_v = v ? ptr1_q : ptr0_q;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      if (!reset_i && !full_q[v]) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr_v) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
   end

   assign win_data = req_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
   assign nxt      = PW'((int'(win) + 1) % NUM_REQ);

   always_comb begin
      gnt_o = '0;
      if (found) gnt_o[win] = 1'b1;
   end

   assign so_o = !reset_i && full_q[t] && ro_i;
   assign do_o = so_o ? obuf_q[t] : '0;

   always_comb begin
      obuf_d   = obuf_q;
      full_d   = full_q;
      ptr0_d   = ptr0_q;
      ptr1_d   = ptr1_q;
      vc_err_d = vc_err_q;
      tx_d     = tx_q;
      if (found) begin
         obuf_d[v] = win_data;
         full_d[v] = 1'b1;
         if (v) ptr1_d = nxt;
         else   ptr0_d = nxt;
         if (win_data[DATA_WIDTH-1] != v) vc_err_d = 1'b1;
      end
      if (so_o) begin
         full_d[t] = 1'b0;
         tx_d      = tx_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         obuf_q   <= '0;
         full_q   <= '0;
         ptr0_q   <= '0;
         ptr1_q   <= '0;
         vc_err_q <= 1'b0;
         tx_q     <= '0;
      end else begin
         obuf_q   <= obuf_d;
         full_q   <= full_d;
         ptr0_q   <= ptr0_d;
         ptr1_q   <= ptr1_d;
         vc_err_q <= vc_err_d;
         tx_q     <= tx_d;
      end
   end

   assign obuf_full_o = full_q;
   assign vc_err_o    = vc_err_q;
   assign tx_count_o  = tx_q;

endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- Output-channel arbiter for one direction of the mesh router (E, W, N, S or PE).
- Shares the output link among NUM_REQ input buffers using per-virtual-channel round-robin.
- Holds one flit per VC (even VC0, odd VC1) in an output buffer.
- Drives the so/ro/do link handshake under the router's global polarity: internal arbitration serves VC == polarity, and the external link drains VC == ~polarity.

Parameters:
- DATA_WIDTH, 64, flit width; bit [DATA_WIDTH-1] is the VC bit.
- NUM_REQ, 4, number of input buffers competing for this output (U-turn excluded).

Ports:
- clk  in  1  router clock.
- reset  in  1  asynchronous, active-high reset.
- polarity  in  1  global polarity from the router; toggles every cycle after reset.
- req  in  NUM_REQ  req[i]=1: input i holds a head flit routed to this output in VC == polarity.
- req_data  in  NUM_REQ*DATA_WIDTH  head flit of input i, in slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot combinational grant; input i pops its flit at the next clk edge.
- so  out  1  send-out to the downstream router.
- ro  in  1  downstream ready for VC ~polarity.
- do  out  DATA_WIDTH  flit to the downstream router.
- obuf_full  out  2  full flags of the VC0 and VC1 output buffers.
- vc_err  out  1  sticky; a granted flit's VC bit did not match polarity.
- tx_count  out  16  flits sent on the link; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous, active-high) clears obuf_full, both round-robin pointers (ptr0, ptr1), vc_err and tx_count. With reset asserted, gnt=0, so=0 and do=0.
- Arbitration VC: v = polarity. Link VC: t = ~polarity. Because v != t in every cycle, one buffer is never filled and drained in the same cycle.
- Grant (combinational):
  - If obuf_full[v]=0 and req != 0, the winner is the first i with req[i]=1, searching ptr_v, ptr_v+1, ... modulo NUM_REQ.
  - gnt is one-hot on the winner; otherwise gnt=0.
  - If obuf_full[v]=1, gnt=0 even when req is asserted (back-pressure to the input buffers).
- Grant (clk edge):
  - obuf[v] <= winner's flit and obuf_full[v] <= 1.
  - ptr_v <= (winner+1) mod NUM_REQ.
  - If the winner's bit [DATA_WIDTH-1] != v, vc_err <= 1; vc_err holds until reset. The flit is still latched.
- Pointers change only on a grant to their own VC; the other VC's pointer is untouched.
- Link output (combinational): so = obuf_full[t] & ro; do = obuf[t] when so=1, else all zeros.
- Link (clk edge): if so=1, obuf_full[t] <= 0 and tx_count <= tx_count+1.
- If ro=0, the flit in obuf[t] is held; it is retried when the polarity next selects t with ro=1.
- Latency: a flit granted in cycle n (polarity=v) is offered on the link no earlier than cycle n+1 (polarity=~v).
- Throughput: one flit per VC every 2 cycles, so full link rate when both VCs are loaded.
- A single requester is granted every time its VC is active and its buffer is free; requests in the inactive VC are ignored.
- Reset mid-operation discards any buffered flits; after reset the first grant starts searching at index 0.

Test Plan:
- Reset then idle: reset=1 for 1 cycle, req=0 -> so=0, do=0, gnt=0, obuf_full=2'b00, tx_count=0.
- Single flit:
  - Stimulus: polarity=1, req=4'b0001, req_data[63:0]=64'hC010_0100_1111_1111, ro=1.
  - Response: gnt=4'b0001; next cycle (polarity=0) so=1, do=64'hC010_0100_1111_1111; tx_count=1; obuf_full=2'b00 afterwards.
- Round-robin fairness:
  - Stimulus: req=4'b1011 held for 6 consecutive VC0 arbitration slots, ro=1.
  - Response: grant order 0,1,3,0,1,3; every granted flit appears on do exactly once, one cycle after its grant.
- Back-pressure:
  - Stimulus: fill obuf[1], hold ro=0 for 4 cycles, req asserted for VC1.
  - Response: so=0 throughout; gnt=0 in every VC1 slot; obuf_full[1]=1; the held flit is sent in the first VC1-drain cycle after ro=1; tx_count increments by 1.
- VC error:
  - Stimulus: polarity=0, req=4'b0100, req_data VC bit=1 (64'h8000_0000_9999_9999).
  - Response: gnt=4'b0100; vc_err=1 from the next cycle and held; the flit is still delivered.
- Reset mid-flight:
  - Stimulus: both buffers full, ro=0, then reset pulse.
  - Response: obuf_full=2'b00 and so=0 immediately (asynchronous); tx_count=0; the next grant with req=4'b1000 goes to input 3, and the next with req=4'b1111 goes to input 0.
